// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants, forwarding types and helpers
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;

  // Where an operand value comes from before the immediate mux.
  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_EX   = 2'b01,
    FWD_WB   = 2'b10
  } fwd_src_e;

  // Add 0..2 to a 16-bit counter, sticking at all-ones.
  function automatic logic [15:0] sat_add16(input logic [15:0] base, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, base} + {15'b0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU for the execute stage
module alu
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      alu_cntrl,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] sub_res;

  // Subtraction is built as A + ~B + 1 so it shares the adder form; wraps mod 2^32.
  assign sub_res = a + ~b + {{(XLEN-1){1'b0}}, 1'b1};

  // Operation select; unlisted encodings fall back to ADD.
  always_comb begin
    result = a + b;
    case (alu_cntrl)
      ALU_ADD: result = a + b;
      ALU_SUB: result = sub_res;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      default: result = a + b;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: operand forwarding, ALU and EX pipeline register
module ex_stage
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            stall,
  input  logic            flush,
  input  logic [2:0]      alu_cntrl,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic            alu_src,
  input  logic [4:0]      rd_addr,
  input  logic            reg_write,
  input  logic [4:0]      wb_rd,
  input  logic            wb_we,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  output logic [XLEN-1:0] ex_result,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_write,
  output logic            ex_zero,
  output logic [15:0]     fwd_count
);

  fwd_src_e        src_a;
  fwd_src_e        src_b;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b_fwd;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_result;
  logic            fwd_a;
  logic            fwd_b;
  logic [1:0]      fwd_inc;
  logic            capture;

  // ex_reg_write is already gated by out_valid, so it alone marks a live EX producer.
  // x0 is hardwired zero and never forwarded.
  always_comb begin
    src_a = FWD_NONE;
    if (rs1_addr != 5'd0) begin
      if (out_valid && ex_reg_write && (ex_rd == rs1_addr))
        src_a = FWD_EX;
      else if (wb_we && (wb_rd == rs1_addr))
        src_a = FWD_WB;
    end
  end

  // Operand B source select, same priority as operand A.
  always_comb begin
    src_b = FWD_NONE;
    if (rs2_addr != 5'd0) begin
      if (out_valid && ex_reg_write && (ex_rd == rs2_addr))
        src_b = FWD_EX;
      else if (wb_we && (wb_rd == rs2_addr))
        src_b = FWD_WB;
    end
  end

  // Operand muxes; the immediate overrides the forwarded rs2 value.
  always_comb begin
    case (src_a)
      FWD_EX:  op_a = ex_result;
      FWD_WB:  op_a = wb_data;
      default: op_a = rs1_data;
    endcase
    case (src_b)
      FWD_EX:  op_b_fwd = ex_result;
      FWD_WB:  op_b_fwd = wb_data;
      default: op_b_fwd = rs2_data;
    endcase
    op_b = alu_src ? imm : op_b_fwd;
  end

  alu u_alu (
    .a         (op_a),
    .b         (op_b),
    .alu_cntrl (alu_cntrl),
    .result    (alu_result)
  );

  // An EX+WB double match is one forward; rs2 only counts when it feeds the ALU.
  assign fwd_a   = (src_a != FWD_NONE);
  assign fwd_b   = (src_b != FWD_NONE) && !alu_src;
  assign fwd_inc = {1'b0, fwd_a} + {1'b0, fwd_b};
  assign capture = !stall && !flush;

  // EX pipeline register: flush bubbles the stage even while stalled, stall freezes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      ex_result    <= '0;
      ex_rd        <= 5'd0;
      ex_reg_write <= 1'b0;
      ex_zero      <= 1'b1;
    end else if (flush) begin
      out_valid    <= 1'b0;
      ex_reg_write <= 1'b0;
    end else if (capture) begin
      out_valid    <= in_valid;
      ex_result    <= alu_result;
      ex_rd        <= rd_addr;
      ex_reg_write <= in_valid && reg_write;
      ex_zero      <= (alu_result == '0);
    end
  end

  // Saturating forward counter, advanced only by instructions that actually enter EX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      fwd_count <= 16'd0;
    else if (capture && in_valid)
      fwd_count <= sat_add16(fwd_count, fwd_inc);
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - scoreboard testbench for ex_stage
module tb_ex_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        stall;
  logic        flush;
  logic [2:0]  alu_cntrl;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic        alu_src;
  logic [4:0]  rd_addr;
  logic        reg_write;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic [31:0] wb_data;
  logic        out_valid;
  logic [31:0] ex_result;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_zero;
  logic [15:0] fwd_count;

  ex_stage dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .stall        (stall),
    .flush        (flush),
    .alu_cntrl    (alu_cntrl),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .imm          (imm),
    .alu_src      (alu_src),
    .rd_addr      (rd_addr),
    .reg_write    (reg_write),
    .wb_rd        (wb_rd),
    .wb_we        (wb_we),
    .wb_data      (wb_data),
    .out_valid    (out_valid),
    .ex_result    (ex_result),
    .ex_rd        (ex_rd),
    .ex_reg_write (ex_reg_write),
    .ex_zero      (ex_zero),
    .fwd_count    (fwd_count)
  );

  typedef struct packed {
    logic        v;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rw;
    logic        z;
    logic [15:0] cnt;
  } exp_t;

  localparam exp_t RESET_EXP = '{v: 1'b0, res: 32'd0, rd: 5'd0, rw: 1'b0, z: 1'b1, cnt: 16'd0};

  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] c0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_instr(input logic [2:0] op, input logic [4:0] r1, input logic [31:0] d1,
                           input logic [4:0] r2, input logic [31:0] d2, input logic [31:0] iv,
                           input logic src, input logic [4:0] rd, input logic rw);
    in_valid  = 1'b1;
    stall     = 1'b0;
    flush     = 1'b0;
    alu_cntrl = op;
    rs1_addr  = r1;
    rs1_data  = d1;
    rs2_addr  = r2;
    rs2_data  = d2;
    imm       = iv;
    alu_src   = src;
    rd_addr   = rd;
    reg_write = rw;
    wb_we     = 1'b0;
  endtask

  // Predict the next EX state from the driven inputs, push it, clock, then pop and compare.
  task automatic step();
    exp_t        e;
    exp_t        got;
    logic        ea, wa, eb, wbb;
    logic [31:0] a, bf, b, res;
    int          nf;
    e   = cur;
    ea  = cur.v && cur.rw && (cur.rd == rs1_addr) && (rs1_addr != 0);
    wa  = wb_we && (wb_rd == rs1_addr) && (rs1_addr != 0);
    eb  = cur.v && cur.rw && (cur.rd == rs2_addr) && (rs2_addr != 0);
    wbb = wb_we && (wb_rd == rs2_addr) && (rs2_addr != 0);
    a   = ea ? cur.res : (wa ? wb_data : rs1_data);
    bf  = eb ? cur.res : (wbb ? wb_data : rs2_data);
    b   = alu_src ? imm : bf;
    case (alu_cntrl)
      3'b110:  res = a - b;
      3'b000:  res = a & b;
      3'b001:  res = a | b;
      3'b011:  res = a ^ b;
      default: res = a + b;
    endcase
    nf = ((ea || wa) ? 1 : 0) + ((!alu_src && (eb || wbb)) ? 1 : 0);
    if (flush) begin
      e.v  = 1'b0;
      e.rw = 1'b0;
    end else if (!stall) begin
      e.v   = in_valid;
      e.res = res;
      e.rd  = rd_addr;
      e.rw  = in_valid && reg_write;
      e.z   = (res == 32'd0);
      if (in_valid)
        e.cnt = (int'(cur.cnt) + nf > 65535) ? 16'hFFFF : 16'(int'(cur.cnt) + nf);
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check("out_valid", {31'd0, out_valid}, {31'd0, got.v});
    check("ex_result", ex_result, got.res);
    check("ex_rd", {27'd0, ex_rd}, {27'd0, got.rd});
    check("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, got.rw});
    check("ex_zero", {31'd0, ex_zero}, {31'd0, got.z});
    check("fwd_count", {16'd0, fwd_count}, {16'd0, got.cnt});
    check("rw_gated", {31'd0, ex_reg_write & ~out_valid}, 32'd0);
    cur = got;
  endtask

  // Pulse reset between edges with a live instruction on the inputs; it must clear at once
  // and the instruction present at the next edge must be discarded.
  task automatic do_reset();
    #2 rst = 1'b1;
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_reg_write", {31'd0, ex_reg_write}, 32'd0);
    check("rst_result", ex_result, 32'd0);
    check("rst_rd", {27'd0, ex_rd}, 32'd0);
    check("rst_zero", {31'd0, ex_zero}, 32'd1);
    check("rst_fwd_count", {16'd0, fwd_count}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_discard_valid", {31'd0, out_valid}, 32'd0);
    check("rst_discard_count", {16'd0, fwd_count}, 32'd0);
    rst = 1'b0;
    cur = RESET_EXP;
  endtask

  initial begin
    rst = 1'b0;
    set_instr(3'b010, 5'd1, 32'd1, 5'd1, 32'd1, 32'd0, 1'b0, 5'd1, 1'b1);
    wb_rd   = 5'd0;
    wb_data = 32'd0;
    cur     = RESET_EXP;
    @(posedge clk);
    #1;
    do_reset();

    // ADD 5 + 7 with no hazards
    set_instr(3'b010, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 1'b0, 5'd6, 1'b1);
    step();
    check("add_result", ex_result, 32'd12);
    check("add_zero", {31'd0, ex_zero}, 32'd0);
    check("add_valid", {31'd0, out_valid}, 32'd1);

    // Back-to-back: x3 = 0x10, then x4 = x3 - x3 with both operands forwarded from EX
    do_reset();
    set_instr(3'b010, 5'd1, 32'h10, 5'd0, 32'd0, 32'd0, 1'b1, 5'd3, 1'b1);
    step();
    set_instr(3'b110, 5'd3, 32'hDEAD, 5'd3, 32'hBEEF, 32'd0, 1'b0, 5'd4, 1'b1);
    step();
    check("b2b_result", ex_result, 32'd0);
    check("b2b_zero", {31'd0, ex_zero}, 32'd1);
    check("b2b_fwd_count", {16'd0, fwd_count}, 32'd2);

    // EX (0xAA) and WB (0x55) both target x5: EX wins, counted once
    set_instr(3'b010, 5'd1, 32'hAA, 5'd0, 32'd0, 32'd0, 1'b1, 5'd5, 1'b1);
    step();
    c0 = fwd_count;
    set_instr(3'b011, 5'd5, 32'h11, 5'd0, 32'd0, 32'hFF, 1'b1, 5'd8, 1'b1);
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h55;
    step();
    check("exwb_result", ex_result, 32'h55);
    check("exwb_fwd_count", {16'd0, fwd_count}, {16'd0, c0 + 16'd1});

    // Stall three cycles with changing inputs, then flush while stalled
    set_instr(3'b001, 5'd1, 32'hF0, 5'd2, 32'h0F, 32'd0, 1'b0, 5'd9, 1'b1);
    step();
    for (int i = 0; i < 3; i++) begin
      stall     = 1'b1;
      rs1_data  = 32'(i * 3 + 1);
      alu_cntrl = 3'(i);
      rd_addr   = 5'(12 + i);
      step();
      check("stall_result", ex_result, 32'hFF);
      check("stall_rd", {27'd0, ex_rd}, 32'd9);
    end
    flush = 1'b1;
    step();
    check("flush_stall_valid", {31'd0, out_valid}, 32'd0);
    check("flush_stall_rw", {31'd0, ex_reg_write}, 32'd0);

    // Write to x0, then read x0: never forwarded from EX or WB
    set_instr(3'b010, 5'd1, 32'h77, 5'd0, 32'd0, 32'd0, 1'b1, 5'd0, 1'b1);
    step();
    c0 = fwd_count;
    set_instr(3'b010, 5'd0, 32'h1234, 5'd0, 32'd0, 32'd1, 1'b1, 5'd10, 1'b1);
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hBAD;
    step();
    check("x0_result", ex_result, 32'h1235);
    check("x0_fwd_count", {16'd0, fwd_count}, {16'd0, c0});

    // Async reset in the middle of a stall, then an unlisted opcode acts as ADD
    set_instr(3'b010, 5'd1, 32'd3, 5'd2, 32'd4, 32'd0, 1'b0, 5'd11, 1'b1);
    step();
    stall = 1'b1;
    do_reset();
    set_instr(3'b111, 5'd1, 32'd100, 5'd2, 32'd23, 32'd0, 1'b0, 5'd11, 1'b1);
    step();
    check("op111_result", ex_result, 32'd123);
    check("op111_valid", {31'd0, out_valid}, 32'd1);

    // Random mix of hazards, stalls and flushes
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      stall     = ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 7) == 0);
      alu_cntrl = 3'($urandom_range(0, 7));
      rs1_addr  = 5'($urandom_range(0, 3));
      rs2_addr  = 5'($urandom_range(0, 3));
      rs1_data  = $urandom;
      rs2_data  = ($urandom_range(0, 3) == 0) ? rs1_data : $urandom;
      imm       = $urandom;
      alu_src   = $urandom_range(0, 1) == 1;
      rd_addr   = 5'($urandom_range(0, 3));
      reg_write = $urandom_range(0, 3) != 0;
      wb_we     = $urandom_range(0, 1) == 1;
      wb_rd     = 5'($urandom_range(0, 3));
      wb_data   = $urandom;
      step();
    end

    // Drive fwd_count into saturation with two forwards per instruction
    do_reset();
    set_instr(3'b010, 5'd7, 32'd1, 5'd7, 32'd1, 32'd0, 1'b0, 5'd7, 1'b1);
    for (int i = 0; i < 32772; i++)
      step();
    check("sat_fwd_count", {16'd0, fwd_count}, 32'h0000FFFF);

    check("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
